// File: rtl/logic_sweep_checker_if.sv
// Bus between the sweep checker and whoever owns it: start/status handshake,
// pattern drive to the logic unit, result return and mismatch count.
// Define LOGIC_SWEEP_FAIL_CAPTURE_EN to add the first-failure capture signals.
interface logic_sweep_checker_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] dut_in;
  logic [9:0] res_i;
  logic [8:0] err_cnt;
`ifdef LOGIC_SWEEP_FAIL_CAPTURE_EN
  logic       fail_valid;
  logic [7:0] fail_vec;
  logic [9:0] fail_res;

  modport master (output start, res_i,
                  input  busy, done, pass, dut_in, err_cnt,
                         fail_valid, fail_vec, fail_res);
  modport slave  (input  start, res_i,
                  output busy, done, pass, dut_in, err_cnt,
                         fail_valid, fail_vec, fail_res);
`else
  modport master (output start, res_i,
                  input  busy, done, pass, dut_in, err_cnt);
  modport slave  (input  start, res_i,
                  output busy, done, pass, dut_in, err_cnt);
`endif
endinterface

// File: rtl/logic_sweep_checker.sv
// Exhaustive sweep checker for the 8-in/10-out logic unit: drives all 256
// patterns, compares the unit results LAT cycles later against a golden
// vector and counts mismatching patterns (saturating at 256).
// Optional first-failure capture: define LOGIC_SWEEP_FAIL_CAPTURE_EN.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | driving patterns 0..255, one per cycle
// DRAIN | holding pattern 255 for LAT cycles while the last results arrive
// DONE  | sweep complete, done/pass/err_cnt valid; start re-arms
module logic_sweep_checker #(
  parameter int LAT = 0
) (
  input logic            clk,
  input logic            rst,
  logic_sweep_checker_if.slave bus
);

`ifdef LOGIC_SWEEP_FAIL_CAPTURE_EN
  localparam int PW = 8;
`else
  // Without capture only the pattern bits that feed the golden vector travel
  // down the delay line.
  localparam int PW = 4;
`endif

  localparam logic [2:0] DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic [7:0]    pat_cnt;
  logic [2:0]    drain_cnt;
  logic [8:0]    err_q;
  logic          running;
  logic          cmp_vld;
  logic [PW-1:0] cmp_pat;
  logic [9:0]    golden;
  logic          mismatch;
  logic          ga, gb, gc, gd;

  assign running = (state == RUN);

  // Next-state decode and start acceptance
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (pat_cnt == 8'hff) state_nxt = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        if (drain_cnt == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pattern counter and drain down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_cnt   <= 8'd0;
      drain_cnt <= 3'd0;
    end else if (accept) begin
      pat_cnt   <= 8'd0;
    end else if (running) begin
      if (pat_cnt != 8'hff) pat_cnt <= pat_cnt + 8'd1;
      else                  drain_cnt <= DRAIN_LOAD;
    end else if (state == DRAIN && drain_cnt != 3'd0) begin
      drain_cnt <= drain_cnt - 3'd1;
    end
  end

  // Expected-response delay line: pattern and valid delayed LAT stages
  generate
    if (LAT == 0) begin : g_nolat
      assign cmp_vld = running;
      assign cmp_pat = pat_cnt[7 -: PW];
    end else begin : g_lat
      logic [LAT-1:0] vld_sr;
      logic [PW-1:0]  pat_sr [LAT];

      // Shift valid (reset-cleared) and pattern one stage per cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_sr <= '0;
        end else begin
          vld_sr[0] <= running;
          for (int i = 1; i < LAT; i++) vld_sr[i] <= vld_sr[i-1];
        end
        pat_sr[0] <= pat_cnt[7 -: PW];
        for (int i = 1; i < LAT; i++) pat_sr[i] <= pat_sr[i-1];
      end

      assign cmp_vld = vld_sr[LAT-1];
      assign cmp_pat = pat_sr[LAT-1];
    end
  endgenerate

  assign ga = cmp_pat[PW-1];
  assign gb = cmp_pat[PW-2];
  assign gc = cmp_pat[PW-3];
  assign gd = cmp_pat[PW-4];

  assign golden = {(ga | gb) | (gc | gd), (ga | gb) & (gc | gd), ga, ~ga,
                   ~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};

  assign mismatch = cmp_vld && (bus.res_i != golden);

  // Mismatch counter: one count per failing pattern, saturating at 256
  always_ff @(posedge clk) begin
    if (rst || accept)                  err_q <= 9'd0;
    else if (mismatch && err_q != 9'd256) err_q <= err_q + 9'd1;
  end

`ifdef LOGIC_SWEEP_FAIL_CAPTURE_EN
  logic       fail_vld_q;
  logic [7:0] fail_vec_q;
  logic [9:0] fail_res_q;

  // Latch the first failing pattern and observed result of each sweep
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      fail_vld_q <= 1'b0;
      fail_vec_q <= 8'd0;
      fail_res_q <= 10'd0;
    end else if (mismatch && !fail_vld_q) begin
      fail_vld_q <= 1'b1;
      fail_vec_q <= cmp_pat;
      fail_res_q <= bus.res_i;
    end
  end

  assign bus.fail_valid = fail_vld_q;
  assign bus.fail_vec   = fail_vec_q;
  assign bus.fail_res   = fail_res_q;
`endif

  assign bus.busy    = (state == RUN) || (state == DRAIN);
  assign bus.done    = (state == DONE);
  assign bus.pass    = (state == DONE) && (err_q == 9'd0);
  assign bus.dut_in  = pat_cnt;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: a LAT=0 and a LAT=3 instance, each driving a
// behavioural logic unit (correct, B5 stuck-at-0, or extra pipeline stages).
// Expected sweep outcomes are queued when a sweep starts and checked by a
// monitor when done rises.
module tb_logic_sweep_checker;

  typedef struct {
    string      nm;
    int         cyc;
    int         err;
    bit         any_err;
    bit         fval;
    bit         fchk;
    logic [7:0] fvec;
    logic [9:0] fres;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start0, start3;
  int   mode;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;

  exp_t q0[$];
  exp_t q3[$];
  exp_t mon_e;

  logic       busy_s [2];
  logic       done_s [2];
  logic       pass_s [2];
  logic [7:0] din_s  [2];
  logic [8:0] err_s  [2];
  logic [9:0] res_s  [2];
  logic       done_q [2];
`ifdef LOGIC_SWEEP_FAIL_CAPTURE_EN
  logic       fv_s [2];
  logic [7:0] fvec_s [2];
  logic [9:0] fres_s [2];
`endif

  logic_sweep_checker_if bus0 ();
  logic_sweep_checker_if bus3 ();

  logic_sweep_checker #(.LAT(0)) u_lat0 (.clk(clk), .rst(rst), .bus(bus0));
  logic_sweep_checker #(.LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus0.start = start0;
  assign bus3.start = start3;
  assign bus0.res_i = res_s[0];
  assign bus3.res_i = res_s[1];
  assign busy_s[0] = bus0.busy;    assign busy_s[1] = bus3.busy;
  assign done_s[0] = bus0.done;    assign done_s[1] = bus3.done;
  assign pass_s[0] = bus0.pass;    assign pass_s[1] = bus3.pass;
  assign din_s[0]  = bus0.dut_in;  assign din_s[1]  = bus3.dut_in;
  assign err_s[0]  = bus0.err_cnt; assign err_s[1]  = bus3.err_cnt;
`ifdef LOGIC_SWEEP_FAIL_CAPTURE_EN
  assign fv_s[0]   = bus0.fail_valid; assign fv_s[1]   = bus3.fail_valid;
  assign fvec_s[0] = bus0.fail_vec;   assign fvec_s[1] = bus3.fail_vec;
  assign fres_s[0] = bus0.fail_res;   assign fres_s[1] = bus3.fail_res;
`endif

  // Reference logic unit: unit in[0] is pattern bit 7 (a), in[1] bit 6 (b) ...
  function automatic logic [9:0] gold(input logic [7:0] p);
    logic a, b, c, d;
    logic [9:0] r;
    a = p[7]; b = p[6]; c = p[5]; d = p[4];
    r[0] = a & b;
    r[1] = a | b;
    r[2] = ~(a & b);
    r[3] = ~(a | b);
    r[4] = a ^ b;
    r[5] = ~(a ^ b);
    r[6] = ~a;
    r[7] = a;
    r[8] = (a | b) && (c | d);
    r[9] = (a | b) || (c | d);
    return r;
  endfunction

  logic [9:0] p1, d3a, d3b, d3c;
  always @(posedge clk) begin
    p1  <= gold(din_s[0]);
    d3a <= gold(din_s[1]);
    d3b <= d3a;
    d3c <= d3b;
  end

  // mode 0: correct unit, 1: B5 stuck at 0, 2: correct but one cycle late
  assign res_s[0] = (mode == 1) ? (gold(din_s[0]) & 10'h3ef) :
                    (mode == 2) ? p1 : gold(din_s[0]);
  assign res_s[1] = d3c;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
  endtask

  task automatic drive_start(input int d, input logic v);
    if (d == 0) start0 = v;
    else        start3 = v;
  endtask

  // Issue one sweep from a negedge; expectation goes to the scoreboard.
  task automatic sweep(input int d, input string nm, input int exp_err,
                       input bit any_err, input bit pulses, input bit fval,
                       input bit fchk, input logic [7:0] fvec,
                       input logic [9:0] fres);
    exp_t e;
    int   lat;
    bit   seen;
    lat = (d == 0) ? 0 : 3;
    e.nm = nm; e.cyc = cyc + 257 + lat; e.err = exp_err; e.any_err = any_err;
    e.fval = fval; e.fchk = fchk; e.fvec = fvec; e.fres = fres;
    if (d == 0) q0.push_back(e);
    else        q3.push_back(e);
    drive_start(d, 1'b1);
    @(negedge clk);
    drive_start(d, 1'b0);
    chk({nm, "_busy_c1"}, busy_s[d], 1);
    chk({nm, "_din_c1"}, din_s[d], 0);
    for (int n = 2; n <= 256; n++) begin
      @(negedge clk);
      if (pulses) drive_start(d, (n == 10 || n == 100));
    end
    chk({nm, "_busy_c256"}, busy_s[d], 1);
    chk({nm, "_din_c256"}, din_s[d], 255);
    seen = 1'b0;
    for (int k = 0; k < lat + 20 && !seen; k++) begin
      @(negedge clk);
      seen = done_s[d];
    end
    chk({nm, "_done_seen"}, seen, 1);
  endtask

  // Scoreboard monitor: on each rising done, pop and compare the outcome
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_s[d] && !done_q[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q3.size() == 0)) begin
          n_tot++;
          $display("FAIL unexpected_done: inst %0d raised done at cycle %0d with nothing expected", d, cyc);
        end else begin
          mon_e = (d == 0) ? q0.pop_front() : q3.pop_front();
          chk({mon_e.nm, "_done_cycle"}, cyc, mon_e.cyc);
          chk({mon_e.nm, "_busy_at_done"}, busy_s[d], 0);
          if (mon_e.any_err) begin
            chk({mon_e.nm, "_err_nonzero"}, int'(err_s[d] != 9'd0), 1);
            chk({mon_e.nm, "_pass"}, pass_s[d], 0);
          end else begin
            chk({mon_e.nm, "_err_cnt"}, err_s[d], mon_e.err);
            chk({mon_e.nm, "_pass"}, pass_s[d], int'(mon_e.err == 0));
          end
`ifdef LOGIC_SWEEP_FAIL_CAPTURE_EN
          chk({mon_e.nm, "_fail_valid"}, fv_s[d], mon_e.fval);
          if (mon_e.fchk) begin
            chk({mon_e.nm, "_fail_vec"}, fvec_s[d], mon_e.fvec);
            chk({mon_e.nm, "_fail_res"}, fres_s[d], mon_e.fres);
          end
`endif
        end
      end
      done_q[d] <= done_s[d];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start3 = 1'b0; mode = 0;
    done_q[0] = 1'b0; done_q[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy_s[d], 0);
      chk("rst_done", done_s[d], 0);
      chk("rst_pass", pass_s[d], 0);
      chk("rst_din", din_s[d], 0);
      chk("rst_err", err_s[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    sweep(1, "lat3_ok", 0, 0, 0, 0, 0, 8'h00, 10'h000);
    sweep(0, "lat0_ok", 0, 0, 0, 0, 0, 8'h00, 10'h000);
    mode = 1;
    sweep(0, "b5_stuck", 128, 0, 0, 1, 1, 8'h40, 10'h246);
    mode = 2;
    sweep(0, "pipe1_lat0", 0, 1, 0, 1, 0, 8'h00, 10'h000);
    mode = 0;
    sweep(0, "start_pulses", 0, 0, 1, 0, 0, 8'h00, 10'h000);

    // Abort a B5-stuck sweep at pattern 100 with reset
    mode = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_din_100", din_s[0], 100);
    chk("mid_err_36", err_s[0], 36);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy_s[0], 0);
    chk("mid_rst_done", done_s[0], 0);
    chk("mid_rst_pass", pass_s[0], 0);
    chk("mid_rst_din", din_s[0], 0);
    chk("mid_rst_err", err_s[0], 0);
`ifdef LOGIC_SWEEP_FAIL_CAPTURE_EN
    chk("mid_rst_fail_valid", fv_s[0], 0);
`endif
    rst = 1'b0;
    mode = 0;
    sweep(0, "post_rst", 0, 0, 0, 0, 0, 8'h00, 10'h000);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q0.size() + q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
